// File: rtl/serial_mac_neuron.sv
`default_nettype none
// ============================================================================
// Module      : serial_mac_neuron
// Description : Time-multiplexed neuron. One (input, weight) pair per cycle is
//               multiplied and accumulated over N_INPUTS beats. The sum gets a
//               fractionally aligned bias, is rescaled, optionally passed
//               through ReLU, and is saturated to DATA_W bits. The result is
//               held on a valid/ready output until it is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mac_neuron #(
    parameter int N_INPUTS  = 784,
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 6,
    parameter int ACT_MODE  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    // Counter holds 0..N_INPUTS-1; the accumulator has one guard bit beyond
    // the worst-case sum of N_INPUTS full-scale products.
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + CNT_W + 1;

    localparam logic [1:0] c_st_accum  = 2'd0;
    localparam logic [1:0] c_st_finish = 2'd1;
    localparam logic [1:0] c_st_out    = 2'd2;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(N_INPUTS - 1);

    // Saturation bounds in the widened post-shift domain; ~max == min.
    localparam logic signed [ACC_W:0] c_sat_max =
        {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] c_sat_min = ~c_sat_max;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_data;
    logic                    r_out_sat;

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_acc_ext;
    logic signed [ACC_W:0]    w_bias_ext;
    logic signed [ACC_W:0]    w_z;
    logic signed [ACC_W:0]    w_y;
    logic signed [ACC_W:0]    w_act;
    logic [DATA_W-1:0]        w_sat_data;
    logic                     w_sat_flag;
    logic                     w_accept;

    // Operands are sign-extended to the product width so the multiply is a
    // full-precision signed product without relying on context widening.
    assign w_a        = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_b        = {{DATA_W{in_weight[DATA_W-1]}}, in_weight};
    assign w_prod     = w_a * w_b;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // The bias carries FRAC_BITS of fraction while products carry
    // 2*FRAC_BITS, so it is shifted up before the add; the sum is then
    // shifted back down with floor semantics.
    assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
    assign w_bias_ext = {{(ACC_W + 1 - DATA_W){bias[DATA_W-1]}}, bias};
    assign w_z        = w_acc_ext + (w_bias_ext <<< FRAC_BITS);
    assign w_y        = w_z >>> FRAC_BITS;

    assign w_accept  = in_valid && (r_state == c_st_accum);
    assign in_ready  = (r_state == c_st_accum);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    // Activation followed by clipping to the signed DATA_W range.
    always_comb begin
        w_act = w_y;
        if ((ACT_MODE == 1) && w_y[ACC_W]) begin
            w_act = '0;
        end
        w_sat_data = w_act[DATA_W-1:0];
        w_sat_flag = 1'b0;
        if (w_act > c_sat_max) begin
            w_sat_data = c_sat_max[DATA_W-1:0];
            w_sat_flag = 1'b1;
        end else if (w_act < c_sat_min) begin
            w_sat_data = c_sat_min[DATA_W-1:0];
            w_sat_flag = 1'b1;
        end
    end

    // Control FSM, beat counter, accumulator and the held output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_accum;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                c_st_accum: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state <= c_st_finish;
                        end
                    end
                end
                c_st_finish: begin
                    r_out_data  <= w_sat_data;
                    r_out_sat   <= w_sat_flag;
                    r_out_valid <= 1'b1;
                    r_state     <= c_st_out;
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= c_st_accum;
                    end
                end
                default: begin
                    r_state <= c_st_accum;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
